// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, defaults and helpers for the instruction cache refill engine
// Contents: refill_state_t FSM encoding, default geometry, line_align() helper.
package icache_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 16;
  localparam int OFFSET_W_DEF   = $clog2(LINE_WORDS_DEF * WORD_W_DEF / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  // Clears the byte-offset bits of an address; callers narrow the result to
  // their own address width.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned offset_w);
    logic [63:0] mask;
    mask = ~((64'd1 << offset_w) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// rtl/icache_line_buf.sv - LINE_WORDS x WORD_W line assembly buffer with indexed write
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every word)
//   we, idx     write strobe and word slot
//   wdata       word to store
//   line        flat line, word k at [k*WORD_W +: WORD_W]
module icache_line_buf
  import icache_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(LINE_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [LINE_WORDS*WORD_W-1:0] line
);

  logic [WORD_W-1:0] words [LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words[i] <= '0;
      end
    end else if (we) begin
      words[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line[g*WORD_W +: WORD_W] = words[g];
  end

endmodule

// File: rtl/instr_cache_refill.sv
// rtl/instr_cache_refill.sv - instruction cache miss refill engine (one line read, one line write)
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   miss_i, repl_permit_i, pc_f_i  miss request from the cache controller
//   busy_o                         engine not idle (fetch stall)
//   mem_req_*                      line-aligned read request, held until ready
//   mem_rsp_*                      response beats, no backpressure
//   line_we_o, line_addr_o,
//   line_data_o                    single-cycle line write to the cache array
//   protocol_err_o                 sticky beat/last protocol violation flag
module instr_cache_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         miss_i,
  input  logic                         repl_permit_i,
  input  logic [ADDR_W-1:0]            pc_f_i,
  output logic                         busy_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [ADDR_W-1:0]            mem_req_addr_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [WORD_W-1:0]            mem_rsp_data_i,
  input  logic                         mem_rsp_last_i,
  output logic                         line_we_o,
  output logic [ADDR_W-1:0]            line_addr_o,
  output logic [LINE_WORDS*WORD_W-1:0] line_data_o,
  output logic                         protocol_err_o
);

  localparam int OFFSET_W = $clog2(LINE_WORDS * WORD_W / 8);
  localparam int CNT_W    = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  refill_state_t     state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              start;
  logic              beat;
  logic              last_beat;

  assign start     = miss_i && repl_permit_i;
  assign beat      = (state == FILL) && mem_rsp_valid_i;
  // Line length comes from the counter only; mem_rsp_last_i is checked, never obeyed.
  assign last_beat = beat && (cnt == LAST_IDX);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (mem_req_ready_i) state_next = FILL;
      FILL:    if (last_beat) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;

      if (state == IDLE && start) begin
        addr_q <= ADDR_W'(line_align(64'(pc_f_i), OFFSET_W));
      end

      // The final beat leaves the counter parked at LAST_IDX; only the
      // REQ->FILL reload brings it back to 0.
      if (state == REQ && mem_req_ready_i) begin
        cnt <= '0;
      end else if (beat && cnt != LAST_IDX) begin
        cnt <= cnt + 1'b1;
      end

      // Beats outside FILL are dropped but flagged.
      if (mem_rsp_valid_i &&
          (state != FILL || mem_rsp_last_i != (cnt == LAST_IDX))) begin
        err_q <= 1'b1;
      end
    end
  end

  icache_line_buf #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk   (clk_i),
    .rst_n (reset_i),
    .we    (beat),
    .idx   (cnt),
    .wdata (mem_rsp_data_i),
    .line  (line_data_o)
  );

  assign busy_o          = (state != IDLE);
  assign mem_req_valid_o = (state == REQ);
  assign mem_req_addr_o  = addr_q;
  assign line_we_o       = (state == WRITE);
  assign line_addr_o     = addr_q;
  assign protocol_err_o  = err_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// tb/tb_instr_cache_refill.sv - self-checking bench for instr_cache_refill
module tb_instr_cache_refill;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 16;
  localparam int LB = LW * WW;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          miss = 1'b0;
  logic          permit = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [WW-1:0] rsp_data = '0;
  logic          rsp_last = 1'b0;

  logic          busy_o;
  logic          mem_req_valid_o;
  logic [AW-1:0] mem_req_addr_o;
  logic          line_we_o;
  logic [AW-1:0] line_addr_o;
  logic [LB-1:0] line_data_o;
  logic          protocol_err_o;

  instr_cache_refill #(
    .ADDR_W     (AW),
    .WORD_W     (WW),
    .LINE_WORDS (LW)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .miss_i          (miss),
    .repl_permit_i   (permit),
    .pc_f_i          (pc),
    .busy_o          (busy_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (ready),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_data_i  (rsp_data),
    .mem_rsp_last_i  (rsp_last),
    .line_we_o       (line_we_o),
    .line_addr_o     (line_addr_o),
    .line_data_o     (line_data_o),
    .protocol_err_o  (protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] pat(input logic [WW-1:0] base);
    logic [LB-1:0] r;
    for (int k = 0; k < LW; k++) r[k*WW +: WW] = base + WW'(k);
    return r;
  endfunction

  // Behavioural model: outstanding request, words gathered so far, pending write.
  bit            m_req, m_fill, m_we, m_err;
  logic [AW-1:0] m_addr = '0;
  logic [WW-1:0] m_words [LW];
  int            m_n;
  logic [LB-1:0] m_line = '0;

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      m_req = 0; m_fill = 0; m_we = 0; m_err = 0; m_n = 0; m_addr = '0;
    end else if (m_we) begin
      if (rsp_valid) m_err = 1;
      m_we = 0;
    end else if (m_fill) begin
      if (rsp_valid) begin
        if (rsp_last != (m_n == LW - 1)) m_err = 1;
        m_words[m_n] = rsp_data;
        m_n++;
        if (m_n == LW) begin
          m_fill = 0;
          m_we   = 1;
          for (int k = 0; k < LW; k++) m_line[k*WW +: WW] = m_words[k];
        end
      end
    end else if (m_req) begin
      if (rsp_valid) m_err = 1;
      if (ready) begin
        m_req = 0; m_fill = 1; m_n = 0;
      end
    end else begin
      if (rsp_valid) m_err = 1;
      if (miss && permit) begin
        m_req  = 1;
        m_addr = pc & ~(AW'(LW * WW / 8) - 1);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", LB'(busy_o), LB'(m_req | m_fill | m_we));
    chk("req_valid", LB'(mem_req_valid_o), LB'(m_req));
    chk("line_we", LB'(line_we_o), LB'(m_we));
    chk("protocol_err", LB'(protocol_err_o), LB'(m_err));
    if (m_req) chk("req_addr", LB'(mem_req_addr_o), LB'(m_addr));
    if (m_we) begin
      chk("line_addr", LB'(line_addr_o), LB'(m_addr));
      chk("line_data", line_data_o, m_line);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts on the cycle the request is pending with ready high.
  task automatic run_fill(input logic [WW-1:0] base, input logic [LW-1:0] gaps,
                          input int last_at, input int nbeats);
    step();
    for (int k = 0; k < nbeats; k++) begin
      if (gaps[k]) begin
        rsp_valid = 0; rsp_last = 0;
        step();
      end
      rsp_valid = 1;
      rsp_data  = base + WW'(k);
      rsp_last  = (k == last_at);
      step();
    end
    rsp_valid = 0;
    rsp_last  = 0;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] addr, input logic [WW-1:0] base);
    @(negedge clk);
    chk({tag, "_we"}, LB'(line_we_o), LB'(1'b1));
    chk({tag, "_addr"}, LB'(line_addr_o), LB'(addr));
    chk({tag, "_data"}, line_data_o, pat(base));
  endtask

  initial begin
    #2 reset_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", LB'(busy_o), '0);
    chk("rst_req_valid", LB'(mem_req_valid_o), '0);
    chk("rst_req_addr", LB'(mem_req_addr_o), '0);
    chk("rst_line_we", LB'(line_we_o), '0);
    chk("rst_line_addr", LB'(line_addr_o), '0);
    chk("rst_line_data", line_data_o, '0);
    chk("rst_err", LB'(protocol_err_o), '0);
    step();
    reset_i = 1;

    repeat (20) begin
      @(negedge clk);
      chk("idle_no_req", LB'(mem_req_valid_o), '0);
    end
    step();

    // Basic refill, ready already high.
    pc = 32'h0000_1234; miss = 1; permit = 1; ready = 1;
    step();
    miss = 0;
    @(negedge clk);
    chk("t2_req_valid", LB'(mem_req_valid_o), LB'(1'b1));
    chk("t2_req_addr", LB'(mem_req_addr_o), LB'(32'h0000_1200));
    run_fill(32'h100, '0, 15, 16);
    check_write("t2", 32'h0000_1200, 32'h100);
    chk("t2_err", LB'(protocol_err_o), '0);
    step();

    // Miss held while permit is low.
    pc = 32'h0000_8040; miss = 1; permit = 0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_no_req", LB'(mem_req_valid_o), '0);
    end
    step();
    permit = 1;
    step();
    miss = 0;
    @(negedge clk);
    chk("t3_req_valid", LB'(mem_req_valid_o), LB'(1'b1));
    chk("t3_req_addr", LB'(mem_req_addr_o), LB'(32'h0000_8040));
    run_fill(32'h200, '0, 15, 16);
    check_write("t3", 32'h0000_8040, 32'h200);
    step();

    // Request held against low ready while permit and miss drop.
    ready = 0; pc = 32'hABCD_EF7F; miss = 1; permit = 1;
    step();
    miss = 0; permit = 0;
    repeat (7) begin
      @(negedge clk);
      chk("t4_req_hold", LB'(mem_req_valid_o), LB'(1'b1));
      chk("t4_addr_hold", LB'(mem_req_addr_o), LB'(32'hABCD_EF40));
    end
    ready = 1;
    run_fill(32'h300, '0, 15, 16);
    check_write("t4", 32'hABCD_EF40, 32'h300);
    step();
    permit = 1;

    // Gapped beats, last marker one beat early.
    pc = 32'h2000_0010; miss = 1;
    step();
    miss = 0;
    run_fill(32'h400, 16'h0888, 14, 16);
    check_write("t5", 32'h2000_0000, 32'h400);
    repeat (3) begin
      @(negedge clk);
      chk("t5_err_sticky", LB'(protocol_err_o), LB'(1'b1));
    end
    step();

    // Reset mid-fill after beat 8.
    pc = 32'h3000_0040; miss = 1;
    step();
    miss = 0;
    run_fill(32'h500, '0, 15, 9);
    reset_i = 0;
    #1;
    chk("t6_busy", LB'(busy_o), '0);
    chk("t6_req", LB'(mem_req_valid_o), '0);
    chk("t6_err", LB'(protocol_err_o), '0);
    step();
    step();
    reset_i = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_we", LB'(line_we_o), '0);
    end
    step();
    pc = 32'h3000_0040; miss = 1;
    step();
    miss = 0;
    run_fill(32'h600, '0, 15, 16);
    check_write("t6", 32'h3000_0040, 32'h600);

    // Miss raised during the write: next request without an extra gap.
    pc = 32'h0000_4000; miss = 1;
    step();
    step();
    miss = 0;
    @(negedge clk);
    chk("t7_req_valid", LB'(mem_req_valid_o), LB'(1'b1));
    chk("t7_req_addr", LB'(mem_req_addr_o), LB'(32'h0000_4000));
    run_fill(32'h700, '0, 15, 16);
    check_write("t7", 32'h0000_4000, 32'h700);
    step();

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
